// File: rtl/tim_ctrl_pkg.sv
// Shared constants for the TIM configuration controller: register offsets,
// CR bit positions and the preload-transfer state encoding.
package tim_ctrl_pkg;

  localparam int CR   = 0;
  localparam int PSC  = 1;
  localparam int ARR  = 2;
  localparam int CCR1 = 3;
  localparam int CCR2 = 4;
  localparam int SR   = 5;
  localparam int DIER = 6;
  localparam int CNT  = 7;

  localparam int CEN  = 0;
  localparam int DIR  = 1;
  localparam int ARPE = 2;
  localparam int UG   = 3;
  localparam int OPM  = 4;

  localparam int N_SHADOW = 4;
  localparam int N_REGS   = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    XFER
  } state_t;

endpackage

// File: rtl/tim_ctrl_shadow.sv
// One preload/active register pair. With ARPE clear a write goes straight
// through to the active copy; otherwise the active copy loads on xfer.
module tim_ctrl_shadow #(
  parameter int           W       = 16,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wdata,
  input  logic         arpe,
  input  logic         xfer,
  output logic [W-1:0] preload,
  output logic [W-1:0] active
);

  logic [W-1:0] preload_reg;
  logic [W-1:0] active_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      preload_reg <= RST_VAL;
      active_reg  <= RST_VAL;
    end else begin
      if (wr_en) begin
        preload_reg <= wdata;
      end
      // A direct write beats the transfer copy for this one register.
      if (wr_en && !arpe) begin
        active_reg <= wdata;
      end else if (xfer) begin
        active_reg <= preload_reg;
      end
    end
  end

  assign preload = preload_reg;
  assign active  = active_reg;

endmodule

// File: rtl/tim_ctrl.sv
// TIM configuration/sequencing controller: bus register file, preload
// transfer FSM and update interrupt. Macro TIMCTRL_ONE_PULSE_EN adds CR.OPM.
module tim_ctrl
  import tim_ctrl_pkg::*;
#(
  parameter int               ADDR_W  = 4,
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_ARR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bus_wr_en,
  input  logic              bus_rd_en,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  output logic              bus_ready,
  input  logic [CNT_W-1:0]  tim_cnt,
  input  logic              tim_update,
  output logic              tim_en,
  output logic              tim_countdown,
  output logic [CNT_W-1:0]  tim_psc,
  output logic [CNT_W-1:0]  tim_arr,
  output logic [CNT_W-1:0]  tim_ccr1,
  output logic [CNT_W-1:0]  tim_ccr2,
  output logic              irq
);

  logic [N_REGS-1:0] sel;
  logic [N_REGS-1:0] wr_sel;
  logic              rd_do;
  logic              ug;
  logic              preload_wr;
  logic              xfer;

  logic              cen_reg;
  logic              dir_reg;
  logic              arpe_reg;
  logic              opm_bit;
  logic              uif_reg;
  logic              uie_reg;
  logic              bus_ready_reg;
  logic [31:0]       bus_rdata_reg;
  logic [31:0]       rd_word;

  state_t            state_reg;
  state_t            state_next;

  logic [CNT_W-1:0]  pre [N_SHADOW];
  logic [CNT_W-1:0]  act [N_SHADOW];

  genvar gi;

  generate
    for (gi = 0; gi < N_REGS; gi++) begin : g_dec
      assign sel[gi] = (bus_addr == ADDR_W'(gi));
    end
  endgenerate

  assign wr_sel     = bus_wr_en ? sel : '0;
  assign rd_do      = bus_rd_en & ~bus_wr_en;
  assign ug         = wr_sel[CR] & bus_wdata[UG];
  assign preload_wr = |wr_sel[CCR2:PSC];
  assign xfer       = (state_reg == XFER);

  generate
    for (gi = 0; gi < N_SHADOW; gi++) begin : g_shadow
      tim_ctrl_shadow #(
        .W       (CNT_W),
        .RST_VAL ((gi == ARR - PSC) ? RST_ARR : '0)
      ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_sel[PSC + gi]),
        .wdata   (bus_wdata[CNT_W-1:0]),
        .arpe    (arpe_reg),
        .xfer    (xfer),
        .preload (pre[gi]),
        .active  (act[gi])
      );
    end
  endgenerate

  assign tim_psc  = act[0];
  assign tim_arr  = act[1];
  assign tim_ccr1 = act[2];
  assign tim_ccr2 = act[3];

`ifdef TIMCTRL_ONE_PULSE_EN
  logic opm_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      opm_reg <= 1'b0;
    end else if (wr_sel[CR]) begin
      opm_reg <= bus_wdata[OPM];
    end
  end

  assign opm_bit = opm_reg;
`else
  assign opm_bit = 1'b0;
`endif

  // A CR write takes precedence over the one-pulse auto-stop.
  always_ff @(posedge clk) begin
    if (reset) begin
      cen_reg  <= 1'b0;
      dir_reg  <= 1'b0;
      arpe_reg <= 1'b0;
    end else if (wr_sel[CR]) begin
      cen_reg  <= bus_wdata[CEN];
      dir_reg  <= bus_wdata[DIR];
      arpe_reg <= bus_wdata[ARPE];
    end else if (opm_bit && tim_update) begin
      cen_reg  <= 1'b0;
    end
  end

  // Setting UIF wins over a coincident write-1-to-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      uif_reg <= 1'b0;
      uie_reg <= 1'b0;
    end else begin
      if (tim_update || ug) begin
        uif_reg <= 1'b1;
      end else if (wr_sel[SR] && bus_wdata[0]) begin
        uif_reg <= 1'b0;
      end
      if (wr_sel[DIER]) begin
        uie_reg <= bus_wdata[0];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    if (sel[CR]) begin
      rd_word[OPM:CEN] = {opm_bit, 1'b0, arpe_reg, dir_reg, cen_reg};
    end
    if (sel[SR]) begin
      rd_word[0] = uif_reg;
    end
    if (sel[DIER]) begin
      rd_word[0] = uie_reg;
    end
    if (sel[CNT]) begin
      rd_word[CNT_W-1:0] = tim_cnt;
    end
    for (int i = 0; i < N_SHADOW; i++) begin
      if (sel[PSC + i]) begin
        rd_word[CNT_W-1:0] = pre[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_ready_reg <= 1'b0;
      bus_rdata_reg <= '0;
    end else begin
      bus_ready_reg <= bus_wr_en | bus_rd_en;
      if (rd_do) begin
        bus_rdata_reg <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (ug) begin
          state_next = XFER;
        end else if (preload_wr && arpe_reg) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (tim_update || ug) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (ug) begin
          state_next = XFER;
        end else if (preload_wr) begin
          state_next = ARMED;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata[31:CNT_W];

  assign bus_ready     = bus_ready_reg;
  assign bus_rdata     = bus_rdata_reg;
  assign tim_en        = cen_reg;
  assign tim_countdown = dir_reg;
  assign irq           = uif_reg & uie_reg;

endmodule
